input_shift_register: RTL and testbench
=======================================

Name: input_shift_register

Overview:
- Input shift register (ISR) for one PIO state machine.
- Collects bits from the GPIO input path (`in_data`), scratch registers or `mov` sources, and packs them into 32-bit words.
- Pushes completed words into the RX FIFO, either explicitly (PUSH) or by autopush threshold.
- Mirror of the output shift register; sits between the gpio/fsm datapath and the RX fifo's push side.

Parameters:
- none; datapath fixed at 32 bits, shift counter 6 bits.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- in_src  input  32  source data for IN; low `shift_count` bits are used
- shift_en  input  1  IN request this cycle
- shift_count  input  5  bits to shift; 0 encodes 32
- shiftdir  input  1  1 = shift right (new bits enter at MSB), 0 = shift left (new bits enter at LSB)
- autopush  input  1  autopush enable
- push_thresh  input  5  autopush/iffull threshold; 0 encodes 32
- push_en  input  1  explicit PUSH request
- push_iffull  input  1  PUSH acts only if count >= threshold
- push_block  input  1  PUSH stalls when FIFO full (else drops)
- mov_en  input  1  MOV into ISR this cycle
- mov_in  input  32  MOV source
- fifo_full  input  1  RX FIFO full status
- fifo_push  output  1  one-cycle push strobe to RX FIFO (combinational)
- fifo_data  output  32  word pushed, valid while `fifo_push`=1
- mov_out  output  32  current ISR contents (MOV from ISR)
- input_shift_counter  output  6  bits currently held, 0..32
- stall  output  1  fsm must hold pc and reissue nothing
- rx_dropped  output  1  sticky: a non-blocking push was lost

Behaviour:
- Reset (`rst`=1 at edge): isr=0, counter=0, state=IDLE, `rx_dropped`=0, `stall`=0, `fifo_push`=0.
- States:
  - IDLE.
  - PUSH_WAIT: holds a pending push; `stall` = (state==PUSH_WAIT), registered.
- Definitions:
  - N = (`shift_count`==0) ? 32 : `shift_count`.
  - T = (`push_thresh`==0) ? 32 : `push_thresh`.
- Shift:
  - Right: isr' = (isr >> N) | (`in_src`[N-1:0] << (32-N)).
  - Left: isr' = (isr << N) | `in_src`[N-1:0].
  - N=32 gives isr' = `in_src` in both directions.
  - Counter: cnt' = min(cnt+N, 32), saturating.
- Priority in IDLE, one action per cycle: `mov_en` > `push_en` > `shift_en`. Lower-priority requests in the same cycle are ignored; the fsm must not issue them together.
- MOV: isr <= `mov_in`, counter <= 0. No push.
- SHIFT, autopush=0: commit isr', cnt'.
- SHIFT, autopush=1 and cnt' >= T:
  - `fifo_full`=0: `fifo_push`=1, `fifo_data`=isr' in the same cycle; isr <= 0, counter <= 0.
  - `fifo_full`=1: commit isr', cnt'; go to PUSH_WAIT.
- SHIFT, autopush=1 and cnt' < T: commit only.
- PUSH, with `push_iffull`=1 and cnt < T: no-op.
- PUSH otherwise:
  - `fifo_full`=0: `fifo_push`=1, `fifo_data`=isr; isr <= 0, counter <= 0.
  - `fifo_full`=1, `push_block`=1: go to PUSH_WAIT, isr unchanged.
  - `fifo_full`=1, `push_block`=0: no push, isr <= 0, counter <= 0, `rx_dropped` <= 1.
- PUSH_WAIT:
  - All requests are ignored.
  - On the first cycle `fifo_full`=0: `fifo_push`=1, `fifo_data`=isr; isr <= 0, counter <= 0; go to IDLE (`stall` low next cycle).
- Latency: push strobe is zero-cycle relative to the accepting request. `mov_out`/counter reflect the update the cycle after the request.
- `fifo_push` is never asserted while `fifo_full`=1. At most one push per cycle.
- Reset mid-PUSH_WAIT: pending word discarded, state IDLE.
- `rx_dropped` clears only on reset.

Test Plan:
- Left shifts, autopush=0: `in_src`=0xF, N=4, applied 3 times -> isr=0x00000FFF, counter=12, no `fifo_push`.
- Right shift: isr=0, `in_src`=0x5, N=4 -> isr=0x50000000; then `in_src`=0xA, N=4 -> isr=0xA5000000, counter=8.
- Autopush with T=8, `fifo_full`=0: two left shifts of 0xAB, N=4 -> on the second, `fifo_push`=1, `fifo_data`=0xBB; next cycle isr=0, counter=0.
- Autopush while full: T=32, N=32, `in_src`=0xDEADBEEF, `fifo_full`=1 -> `stall`=1 for 3 cycles; drop `fifo_full` -> same-cycle push of 0xDEADBEEF, `stall`=0 next cycle.
- PUSH noblock while full: isr=0x1234, `push_en`=1, `push_block`=0, `fifo_full`=1 -> no push, isr=0, `rx_dropped`=1. `push_iffull`=1 with counter=4<T=8 -> no-op.
- `mov_en` with `mov_in`=0xCAFEF00D plus a simultaneous `shift_en` -> isr=0xCAFEF00D, counter=0, shift ignored. `rst` during PUSH_WAIT -> `stall`=0, isr=0 next cycle.

Source files
------------

// File: rtl/input_shift_register.sv
// Input shift register for one PIO state machine: packs IN/MOV data into
// 32-bit words and pushes them to the RX FIFO explicitly or by autopush.
module input_shift_register (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_src,
  input  logic        shift_en,
  input  logic [4:0]  shift_count,
  input  logic        shiftdir,
  input  logic        autopush,
  input  logic [4:0]  push_thresh,
  input  logic        push_en,
  input  logic        push_iffull,
  input  logic        push_block,
  input  logic        mov_en,
  input  logic [31:0] mov_in,
  input  logic        fifo_full,
  output logic        fifo_push,
  output logic [31:0] fifo_data,
  output logic [31:0] mov_out,
  output logic [5:0]  input_shift_counter,
  output logic        stall,
  output logic        rx_dropped
);

  localparam int unsigned DataW = 32;
  localparam int unsigned CntW  = 6;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    PUSH_WAIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [DataW-1:0]   isr_q, isr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               dropped_q, dropped_d;

  logic [CntW-1:0]    n, t, cnt_sh;
  logic [CntW:0]      cnt_sum;
  logic [DataW-1:0]   in_masked, isr_sh;
  logic               push_c;
  logic [DataW-1:0]   data_c;

  // Decode 0-encodes-32 fields and compute the post-shift ISR and count.
  always_comb begin
    n         = (shift_count == 5'd0) ? CntW'(32) : CntW'(shift_count);
    t         = (push_thresh == 5'd0) ? CntW'(32) : CntW'(push_thresh);
    in_masked = in_src & DataW'((64'd1 << n) - 64'd1);
    if (shiftdir)
      isr_sh = (isr_q >> n) | (in_masked << (CntW'(32) - n));
    else
      isr_sh = (isr_q << n) | in_masked;
    cnt_sum = (CntW+1)'(cnt_q) + (CntW+1)'(n);
    cnt_sh  = (cnt_sum > (CntW+1)'(32)) ? CntW'(32) : CntW'(cnt_sum);
  end

  always_comb begin
    state_d   = state_q;
    isr_d     = isr_q;
    cnt_d     = cnt_q;
    dropped_d = dropped_q;
    push_c    = 1'b0;
    data_c    = isr_q;
    case (state_q)
      IDLE: begin
        if (mov_en) begin
          isr_d = mov_in;
          cnt_d = '0;
        end else if (push_en) begin
          if (!(push_iffull && (cnt_q < t))) begin
            if (!fifo_full) begin
              push_c = 1'b1;
              isr_d  = '0;
              cnt_d  = '0;
            end else if (push_block) begin
              state_d = PUSH_WAIT;
            end else begin
              isr_d     = '0;
              cnt_d     = '0;
              dropped_d = 1'b1;
            end
          end
        end else if (shift_en) begin
          if (autopush && (cnt_sh >= t)) begin
            if (!fifo_full) begin
              push_c = 1'b1;
              data_c = isr_sh;
              isr_d  = '0;
              cnt_d  = '0;
            end else begin
              isr_d   = isr_sh;
              cnt_d   = cnt_sh;
              state_d = PUSH_WAIT;
            end
          end else begin
            isr_d = isr_sh;
            cnt_d = cnt_sh;
          end
        end
      end
      PUSH_WAIT: begin
        if (!fifo_full) begin
          push_c  = 1'b1;
          isr_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      isr_q     <= '0;
      cnt_q     <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      isr_q     <= isr_d;
      cnt_q     <= cnt_d;
      dropped_q <= dropped_d;
    end
  end

  // Push strobe is same-cycle; suppressed while reset is asserted.
  assign fifo_push           = push_c & ~rst;
  assign fifo_data           = data_c;
  assign mov_out             = isr_q;
  assign input_shift_counter = cnt_q;
  assign stall               = (state_q == PUSH_WAIT);
  assign rx_dropped          = dropped_q;

endmodule

// File: tb/tb_input_shift_register.sv
// Scoreboard bench for input_shift_register: expected pushes are queued by the
// stimulus and retired by an independent monitor on every fifo_push.
module tb_input_shift_register;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_src;
  logic        shift_en;
  logic [4:0]  shift_count;
  logic        shiftdir;
  logic        autopush;
  logic [4:0]  push_thresh;
  logic        push_en;
  logic        push_iffull;
  logic        push_block;
  logic        mov_en;
  logic [31:0] mov_in;
  logic        fifo_full;
  logic        fifo_push;
  logic [31:0] fifo_data;
  logic [31:0] mov_out;
  logic [5:0]  input_shift_counter;
  logic        stall;
  logic        rx_dropped;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  input_shift_register dut (
    .clk(clk), .rst(rst), .in_src(in_src), .shift_en(shift_en),
    .shift_count(shift_count), .shiftdir(shiftdir), .autopush(autopush),
    .push_thresh(push_thresh), .push_en(push_en), .push_iffull(push_iffull),
    .push_block(push_block), .mov_en(mov_en), .mov_in(mov_in),
    .fifo_full(fifo_full), .fifo_push(fifo_push), .fifo_data(fifo_data),
    .mov_out(mov_out), .input_shift_counter(input_shift_counter),
    .stall(stall), .rx_dropped(rx_dropped)
  );

  // Monitor: every push must match the oldest expected word.
  always @(negedge clk) begin
    if (fifo_push) begin
      checks++;
      if (fifo_full) begin
        errors++;
        $display("FAIL push_while_full: fifo_push=1 with fifo_full=1");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_push: got data %08h, none expected", fifo_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (fifo_data !== e) begin
          errors++;
          $display("FAIL push_data: got %08h expected %08h", fifo_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic clear_req();
    shift_en = 0; push_en = 0; mov_en = 0; rst = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_req();
  endtask

  task automatic do_shift(input logic [31:0] d, input logic [4:0] c, input logic dir);
    in_src = d; shift_count = c; shiftdir = dir; shift_en = 1;
    tick();
  endtask

  task automatic do_mov(input logic [31:0] d);
    mov_in = d; mov_en = 1;
    tick();
  endtask

  task automatic do_push(input logic iffull, input logic blk);
    push_iffull = iffull; push_block = blk; push_en = 1;
    tick();
  endtask

  initial begin
    clear_req();
    in_src = 0; shift_count = 0; shiftdir = 0; autopush = 0; push_thresh = 0;
    push_iffull = 0; push_block = 0; mov_in = 0; fifo_full = 0;
    #1;
    rst = 1;
    tick();
    chk("reset_isr", mov_out, 32'h0);
    chk("reset_cnt", 32'(input_shift_counter), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_dropped", 32'(rx_dropped), 32'd0);

    for (int i = 0; i < 3; i++) do_shift(32'hF, 5'd4, 1'b0);
    chk("left_isr", mov_out, 32'h00000FFF);
    chk("left_cnt", 32'(input_shift_counter), 32'd12);

    do_mov(32'h0);
    do_shift(32'h5, 5'd4, 1'b1);
    chk("right1_isr", mov_out, 32'h50000000);
    do_shift(32'hA, 5'd4, 1'b1);
    chk("right2_isr", mov_out, 32'hA5000000);
    chk("right2_cnt", 32'(input_shift_counter), 32'd8);

    do_mov(32'h0);
    autopush = 1; push_thresh = 5'd8;
    do_shift(32'hAB, 5'd4, 1'b0);
    chk("ap_first_cnt", 32'(input_shift_counter), 32'd4);
    exp_q.push_back(32'h000000BB);
    do_shift(32'hAB, 5'd4, 1'b0);
    chk("ap_isr_cleared", mov_out, 32'h0);
    chk("ap_cnt_cleared", 32'(input_shift_counter), 32'd0);

    push_thresh = 5'd0; fifo_full = 1;
    do_shift(32'hDEADBEEF, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("ap_full_stall", 32'(stall), 32'd1);
      if (i < 2) tick();
    end
    chk("ap_full_hold_isr", mov_out, 32'hDEADBEEF);
    fifo_full = 0;
    exp_q.push_back(32'hDEADBEEF);
    tick();
    chk("ap_release_stall", 32'(stall), 32'd0);
    chk("ap_release_isr", mov_out, 32'h0);
    autopush = 0;

    do_mov(32'h1234);
    fifo_full = 1;
    do_push(1'b0, 1'b0);
    fifo_full = 0;
    chk("drop_isr", mov_out, 32'h0);
    chk("drop_flag", 32'(rx_dropped), 32'd1);
    chk("drop_stall", 32'(stall), 32'd0);

    push_thresh = 5'd8;
    do_shift(32'hF, 5'd4, 1'b0);
    do_push(1'b1, 1'b0);
    chk("iffull_noop_isr", mov_out, 32'h0000000F);
    chk("iffull_noop_cnt", 32'(input_shift_counter), 32'd4);
    exp_q.push_back(32'h0000000F);
    do_push(1'b0, 1'b0);
    chk("push_cnt_cleared", 32'(input_shift_counter), 32'd0);
    chk("dropped_sticky", 32'(rx_dropped), 32'd1);

    in_src = 32'hFFFF_FFFF; shift_count = 5'd8; shift_en = 1;
    do_mov(32'hCAFEF00D);
    chk("mov_isr", mov_out, 32'hCAFEF00D);
    chk("mov_cnt", 32'(input_shift_counter), 32'd0);

    fifo_full = 1;
    do_push(1'b0, 1'b1);
    chk("block_stall", 32'(stall), 32'd1);
    chk("block_isr_kept", mov_out, 32'hCAFEF00D);
    fifo_full = 0;
    rst = 1;
    tick();
    chk("rst_wait_stall", 32'(stall), 32'd0);
    chk("rst_wait_isr", mov_out, 32'h0);
    chk("rst_dropped", 32'(rx_dropped), 32'd0);
    tick();
    tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_push: %0d expected pushes never seen, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
